// File: rtl/sc_lanes_pkg.sv
// Shared types and constants for the multi-lane background shift controller.
package sc_lanes_pkg;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_PAUSE = 3'd4
  } state_e;

  localparam logic [1:0] SHIFT_HOLD  = 2'b11;
  localparam logic [1:0] SHIFT_LEFT  = 2'b10;
  localparam logic [1:0] SHIFT_RIGHT = 2'b01;

  localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/sc_statemachine_lanes_if.sv
// Button-side and lane-datapath-side signals of the lane controller.
interface sc_statemachine_lanes_if #(
  parameter int N_LANES = 4,
  parameter int LEVEL_W = 2
);
  logic                   SC_STATEMACHINELANES_startButton_InLow;
  logic                   SC_STATEMACHINELANES_pause_InLow;
  logic [LEVEL_W-1:0]     SC_STATEMACHINELANES_level_In;
  logic                   SC_STATEMACHINELANES_clear_OutLow;
  logic [2*N_LANES-1:0]   SC_STATEMACHINELANES_shiftselection_Out;
  logic [N_LANES-1:0]     SC_STATEMACHINELANES_tick_Out;
  logic [2:0]             SC_STATEMACHINELANES_state_Out;

  // master: board/score side; slave: the controller itself
  modport master (
    output SC_STATEMACHINELANES_startButton_InLow,
    output SC_STATEMACHINELANES_pause_InLow,
    output SC_STATEMACHINELANES_level_In,
    input  SC_STATEMACHINELANES_clear_OutLow,
    input  SC_STATEMACHINELANES_shiftselection_Out,
    input  SC_STATEMACHINELANES_tick_Out,
    input  SC_STATEMACHINELANES_state_Out
  );

  modport slave (
    input  SC_STATEMACHINELANES_startButton_InLow,
    input  SC_STATEMACHINELANES_pause_InLow,
    input  SC_STATEMACHINELANES_level_In,
    output SC_STATEMACHINELANES_clear_OutLow,
    output SC_STATEMACHINELANES_shiftselection_Out,
    output SC_STATEMACHINELANES_tick_Out,
    output SC_STATEMACHINELANES_state_Out
  );
endinterface

// File: rtl/sc_lane_period_counter.sv
// Per-lane down counter: reloads to P-1, freezes when idle, pulses on expiry.
module sc_lane_period_counter
  import sc_lanes_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int BASE_PERIOD = 5000000,
  parameter int LEVEL_W     = 2,
  parameter bit ODD_LANE    = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               hold_i,
  input  logic               run_i,
  input  logic [LEVEL_W-1:0] level_i,
  output logic               expire_o
);

  localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_PERIOD);

  // Odd lanes run at twice the speed; short periods are clamped so a lane never fires every cycle.
  function automatic logic [CNT_W-1:0] lane_period(input logic [LEVEL_W-1:0] lvl);
    logic [CNT_W-1:0] p;
    p = (BASE >> lvl) >> ODD_LANE;
    if (p < CNT_W'(MIN_PERIOD)) p = CNT_W'(MIN_PERIOD);
    return p;
  endfunction

  logic [CNT_W-1:0] reload;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign reload   = lane_period(level_i) - CNT_W'(1);
  assign expire_o = run_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (hold_i || expire_o) cnt_d = reload;
    else if (run_i)         cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= reload;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sc_statemachine_lanes.sv
// Multi-lane background shift controller: start/run/shift/pause FSM with per-lane period counters.
module sc_statemachine_lanes
  import sc_lanes_pkg::*;
#(
  parameter int                 N_LANES     = 4,
  parameter int                 CNT_W       = 24,
  parameter int                 BASE_PERIOD = 5000000,
  parameter logic [N_LANES-1:0] DIR_MASK    = 4'b0101,
  parameter int                 LEVEL_W     = 2
) (
  input logic                    SC_STATEMACHINELANES_CLOCK_50,
  input logic                    SC_STATEMACHINELANES_RESET_InLow,
  sc_statemachine_lanes_if.slave bus
);

  logic clk, rst_n;
  assign clk   = SC_STATEMACHINELANES_CLOCK_50;
  assign rst_n = SC_STATEMACHINELANES_RESET_InLow;

  state_e             state_q, state_d;
  logic [N_LANES-1:0] pending_q, pending_d;
  logic [N_LANES-1:0] expire;
  logic               run_en, hold_en;

  assign run_en  = (state_q == ST_RUN)   || (state_q == ST_SHIFT);
  assign hold_en = (state_q == ST_RESET) || (state_q == ST_START);

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    sc_lane_period_counter #(
      .CNT_W       (CNT_W),
      .BASE_PERIOD (BASE_PERIOD),
      .LEVEL_W     (LEVEL_W),
      .ODD_LANE    ((i % 2) == 1)
    ) u_cnt (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .hold_i   (hold_en),
      .run_i    (run_en),
      .level_i  (bus.SC_STATEMACHINELANES_level_In),
      .expire_o (expire[i])
    );
  end

  // Pending shifts beat a pause request; pause is looked at again in the following RUN cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_START;
      ST_START: if (!bus.SC_STATEMACHINELANES_startButton_InLow) state_d = ST_RUN;
      ST_RUN: begin
        if (pending_q != '0)                             state_d = ST_SHIFT;
        else if (!bus.SC_STATEMACHINELANES_pause_InLow)  state_d = ST_PAUSE;
      end
      ST_SHIFT: state_d = ST_RUN;
      ST_PAUSE: if (bus.SC_STATEMACHINELANES_pause_InLow) state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
  end

  // A fresh expiry in the SHIFT cycle survives the clear of the bits being consumed.
  always_comb begin
    pending_d = pending_q;
    if (state_q == ST_SHIFT) pending_d = '0;
    pending_d = pending_d | expire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  logic [2*N_LANES-1:0] shsel;
  logic [N_LANES-1:0]   tick;

  always_comb begin
    shsel = {N_LANES{SHIFT_HOLD}};
    tick  = '0;
    if (state_q == ST_SHIFT) begin
      for (int i = 0; i < N_LANES; i++) begin
        if (pending_q[i]) begin
          shsel[2*i +: 2] = DIR_MASK[i] ? SHIFT_RIGHT : SHIFT_LEFT;
          tick[i]         = 1'b1;
        end
      end
    end
  end

  assign bus.SC_STATEMACHINELANES_clear_OutLow       = (state_q != ST_RESET);
  assign bus.SC_STATEMACHINELANES_shiftselection_Out = shsel;
  assign bus.SC_STATEMACHINELANES_tick_Out           = tick;
  assign bus.SC_STATEMACHINELANES_state_Out          = state_q;

endmodule

// File: tb/tb_sc_statemachine_lanes.sv
// Directed bench for sc_statemachine_lanes with BASE_PERIOD = 8 (even lanes P=8, odd lanes P=4 at level 0).
module tb_sc_statemachine_lanes;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  sc_statemachine_lanes_if #(.N_LANES(4), .LEVEL_W(2)) bus ();

  sc_statemachine_lanes #(
    .N_LANES     (4),
    .CNT_W       (24),
    .BASE_PERIOD (8),
    .DIR_MASK    (4'b0101),
    .LEVEL_W     (2)
  ) dut (
    .SC_STATEMACHINELANES_CLOCK_50   (clk),
    .SC_STATEMACHINELANES_RESET_InLow(rst_n),
    .bus                             (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [7:0] ss,
                            input logic [3:0] tk);
    chk({tag, "/state"}, 32'(bus.SC_STATEMACHINELANES_state_Out), 32'(st));
    chk({tag, "/shsel"}, 32'(bus.SC_STATEMACHINELANES_shiftselection_Out), 32'(ss));
    chk({tag, "/tick"},  32'(bus.SC_STATEMACHINELANES_tick_Out), 32'(tk));
  endtask

  task automatic do_reset(input logic [1:0] lvl);
    bus.SC_STATEMACHINELANES_level_In       = lvl;
    bus.SC_STATEMACHINELANES_startButton_InLow = 1'b1;
    bus.SC_STATEMACHINELANES_pause_InLow    = 1'b1;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic start_run();
    bus.SC_STATEMACHINELANES_startButton_InLow = 1'b0;
    cyc();
    bus.SC_STATEMACHINELANES_startButton_InLow = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.SC_STATEMACHINELANES_startButton_InLow = 1'b1;
    bus.SC_STATEMACHINELANES_pause_InLow       = 1'b1;
    bus.SC_STATEMACHINELANES_level_In          = 2'd0;

    // Reset held for three cycles, then released into START
    repeat (3) cyc();
    expect_cyc("t1_reset", 3'd0, 8'hFF, 4'h0);
    chk("t1_clear_rst", 32'(bus.SC_STATEMACHINELANES_clear_OutLow), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("t1_state_start", 32'(bus.SC_STATEMACHINELANES_state_Out), 32'd1);
    chk("t1_clear_start", 32'(bus.SC_STATEMACHINELANES_clear_OutLow), 32'd1);

    // Level 0: odd lanes shift every 4 cycles, all lanes together every 8
    bus.SC_STATEMACHINELANES_startButton_InLow = 1'b1;
    cyc();
    chk("t2_hold_start", 32'(bus.SC_STATEMACHINELANES_state_Out), 32'd1);
    start_run();
    chk("t2_r0", 32'(bus.SC_STATEMACHINELANES_state_Out), 32'd2);
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (k >= 5 && (k % 4) == 1)
        expect_cyc($sformatf("t2_r%0d", k), 3'd3, ((k % 8) == 1) ? 8'h99 : 8'hBB,
                   ((k % 8) == 1) ? 4'hF : 4'hA);
      else
        expect_cyc($sformatf("t2_r%0d", k), 3'd2, 8'hFF, 4'h0);
    end

    // Level 2: every lane clamps to period 2, FSM alternates RUN/SHIFT
    do_reset(2'd2);
    start_run();
    chk("t3_r0", 32'(bus.SC_STATEMACHINELANES_state_Out), 32'd2);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      if (k >= 3 && (k % 2) == 1)
        expect_cyc($sformatf("t3_r%0d", k), 3'd3, 8'h99, 4'hF);
      else
        expect_cyc($sformatf("t3_r%0d", k), 3'd2, 8'hFF, 4'h0);
    end

    // Pause entered at r2 for 20 cycles; counting resumes where it stopped
    do_reset(2'd0);
    start_run();
    cyc();
    cyc();
    chk("t4_r2", 32'(bus.SC_STATEMACHINELANES_state_Out), 32'd2);
    bus.SC_STATEMACHINELANES_pause_InLow = 1'b0;
    for (int p = 0; p < 20; p++) begin
      cyc();
      expect_cyc($sformatf("t4_p%0d", p), 3'd4, 8'hFF, 4'h0);
    end
    chk("t4_clear_pause", 32'(bus.SC_STATEMACHINELANES_clear_OutLow), 32'd1);
    bus.SC_STATEMACHINELANES_pause_InLow = 1'b1;
    cyc();
    expect_cyc("t4_q0", 3'd2, 8'hFF, 4'h0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 2)      expect_cyc("t4_q2", 3'd3, 8'hBB, 4'hA);
      else if (k == 6) expect_cyc("t4_q6", 3'd3, 8'h99, 4'hF);
      else             expect_cyc($sformatf("t4_q%0d", k), 3'd2, 8'hFF, 4'h0);
    end

    // Pause requested in the RUN cycle that carries pending: SHIFT, RUN, then PAUSE
    do_reset(2'd0);
    start_run();
    repeat (4) cyc();
    expect_cyc("t5_r4", 3'd2, 8'hFF, 4'h0);
    bus.SC_STATEMACHINELANES_pause_InLow = 1'b0;
    cyc();
    expect_cyc("t5_shift", 3'd3, 8'hBB, 4'hA);
    cyc();
    expect_cyc("t5_run", 3'd2, 8'hFF, 4'h0);
    cyc();
    expect_cyc("t5_pause", 3'd4, 8'hFF, 4'h0);
    bus.SC_STATEMACHINELANES_pause_InLow = 1'b1;
    cyc();
    chk("t5_resume", 32'(bus.SC_STATEMACHINELANES_state_Out), 32'd2);

    // Reset during SHIFT, then no stale shift before a full period
    do_reset(2'd0);
    start_run();
    repeat (5) cyc();
    expect_cyc("t6_shift", 3'd3, 8'hBB, 4'hA);
    rst_n = 1'b0;
    cyc();
    expect_cyc("t6_reset", 3'd0, 8'hFF, 4'h0);
    chk("t6_clear", 32'(bus.SC_STATEMACHINELANES_clear_OutLow), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("t6_start", 32'(bus.SC_STATEMACHINELANES_state_Out), 32'd1);
    start_run();
    chk("t6_r0", 32'(bus.SC_STATEMACHINELANES_state_Out), 32'd2);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 5) expect_cyc("t6_r5", 3'd3, 8'hBB, 4'hA);
      else        expect_cyc($sformatf("t6_r%0d", k), 3'd2, 8'hFF, 4'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_statemachine_lanes.md
Name: sc_statemachine_lanes

Overview:
- Multi-lane successor to the single-lane background shift controller for the Frogger playfield.
- Drives N_LANES background shift registers (cars/logs), each with its own internal period counter and fixed direction. This replaces the external T0 timer input.
- Adds a difficulty level (speed scaling), a pause mode, and per-lane shift pulses.
- Sits between the board buttons and the lane shift-register datapath.

Parameters:
- N_LANES, 4, number of background lanes controlled.
- CNT_W, 24, width of each lane period counter.
- BASE_PERIOD, 5000000, clock cycles between shifts for even lanes at level 0.
- DIR_MASK, 4'b0101, per-lane direction, one bit per lane (N_LANES wide): 1 = shift right (code 01), 0 = shift left (code 10).
- LEVEL_W, 2, width of the level input.

Ports:
- SC_STATEMACHINELANES_CLOCK_50  in  1  system clock; single clock domain.
- SC_STATEMACHINELANES_RESET_InLow  in  1  synchronous, active-low reset.
- SC_STATEMACHINELANES_startButton_InLow  in  1  start request, active low, pre-debounced.
- SC_STATEMACHINELANES_pause_InLow  in  1  pause request, active low (level-sensitive).
- SC_STATEMACHINELANES_level_In  in  LEVEL_W  difficulty level; higher = faster.
- SC_STATEMACHINELANES_clear_OutLow  out  1  clear to lane registers, active low.
- SC_STATEMACHINELANES_shiftselection_Out  out  2*N_LANES  per-lane shift code; lane i occupies bits [2i+1:2i]; 11 = hold, 10 = left, 01 = right.
- SC_STATEMACHINELANES_tick_Out  out  N_LANES  one-cycle pulse per lane that shifts this cycle.
- SC_STATEMACHINELANES_state_Out  out  3  current state encoding, for debug and score logic.

Behaviour:
- Reset: sampled only on a rising clock edge while RESET_InLow = 0. Resulting values:
  - state = RESET
  - pending = 0
  - each lane counter = P_i - 1
  - clear_OutLow = 0, shiftselection = all 11, tick = 0, state_Out = 0
- Reset asserted mid-operation, including during SHIFT: takes effect at the next edge; any pending shifts are discarded.
- States and encoding: RESET = 0, START = 1, RUN = 2, SHIFT = 3, PAUSE = 4. Undefined encodings return to RESET.
- Transitions:
  - RESET -> START unconditionally.
  - START stays while startButton_InLow = 1; goes to RUN when it is 0.
  - RUN -> SHIFT if any pending bit is set.
  - RUN -> PAUSE, else if pause_InLow = 0.
  - RUN stays otherwise.
  - SHIFT -> RUN unconditionally (one-cycle state).
  - PAUSE -> RUN when pause_InLow = 1.
- Priority: pending beats pause. If pause and pending are present together, SHIFT runs first; pause is evaluated in the following RUN cycle.
- Lane period: P_i = (BASE_PERIOD >> level_In) >> (i & 1), clamped to a minimum of 2. Odd lanes therefore run at double speed.
- Lane counters:
  - Decrement only in RUN and SHIFT.
  - Frozen in PAUSE, so the remaining count is preserved.
  - Held at P_i - 1 in RESET and START.
  - On reaching 0: set pending[i] and reload P_i - 1. Expiries therefore occur exactly every P_i active cycles.
- Level changes are applied only at the next reload.
- Pending update in SHIFT: pending bits that were set are cleared. A new expiry in the same cycle sets its bit, and set wins over clear.
- Latency: counter at 0 in cycle t -> pending visible at t+1 -> SHIFT state at t+2.
- Outputs are Moore, decoded from the state and pending registers:
  - clear_OutLow = 0 only in RESET.
  - In SHIFT, lane i with pending[i] = 1 drives its DIR_MASK code and tick[i] = 1. All other lanes drive 11 and tick 0.
  - In every other state, shiftselection = all 11 and tick = 0.
- Width rules: the level shift uses a logical right shift. P_i is computed in CNT_W bits; no overflow is possible given the right-shift-only arithmetic.

Decomposition:
- Shared package sc_lanes_pkg holds:
  - state localparams
  - shift codes SHIFT_HOLD = 2'b11, SHIFT_LEFT = 2'b10, SHIFT_RIGHT = 2'b01
  - the minimum-period constant 2
- One sub-module, sc_lane_period_counter, instantiated N_LANES times through generate. It holds the per-lane down counter, reload, freeze, and expiry pulse.
- The FSM and output decode stay in the top module.

Test Plan:
- Common bench parameters: BASE_PERIOD = 8, N_LANES = 4, DIR_MASK = 4'b0101.
- 1. Reset: hold RESET_InLow = 0 for 3 cycles -> state_Out = 0, clear_OutLow = 0, shiftselection = 8'hFF, tick = 0. After release -> next cycle state 1, clear_OutLow = 1.
- 2. Start and shift pattern: level = 0, drive startButton low for 1 cycle -> RUN. Lanes 1 and 3 alone shift with shiftselection = 8'hBB, tick = 4'b1010. Every second shift, all four lanes coincide with shiftselection = 8'h99, tick = 4'hF. Check the SHIFT spacing matches the 4- and 8-cycle expiries plus the 2-cycle latency.
- 3. Level clamp: level = 2 gives all P_i = 2 (odd lanes clamped) -> FSM alternates RUN/SHIFT; every SHIFT shows 8'h99.
- 4. Pause: assert pause_InLow = 0 for 20 cycles mid-count -> state 4, no ticks, counters frozen. After release, the first expiry arrives after exactly the remaining count.
- 5. Pause/pending collision: pause asserted in the same RUN cycle that pending is set -> SHIFT (tick asserted), then RUN, then PAUSE.
- 6. Reset during SHIFT: RESET_InLow = 0 in a SHIFT cycle -> next edge state 0, shiftselection = 8'hFF. After restart, no stale shift occurs before a full P_i.
